// File: rtl/ni_output_unit.sv
// Transmit half of the PE network interface: arbitrates read responses, output
// activations and a one-shot finish notice into 36-bit flits under credit flow control.
module ni_output_unit #(
  parameter int         CREDITS       = 4,
  parameter int         RESP_DEPTH    = 4,
  parameter logic [3:0] INFO_RD_RESP  = 4'd6,
  parameter logic [3:0] INFO_ACT_OUT  = 4'd7,
  parameter logic [3:0] INFO_FIN_COMP = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  PE_IDX,
  input  logic        rd_resp_valid,
  input  logic [7:0]  rd_resp_dst,
  input  logic [5:0]  rd_resp_addr,
  input  logic [15:0] rd_resp_data,
  output logic        rd_resp_rdy,
  input  logic        out_act_valid,
  input  logic [15:0] out_act_addr,
  input  logic [15:0] out_act_data,
  output logic        out_act_rdy,
  input  logic        comp_fin,
  input  logic        downstream_credit,
  output logic        out_data_valid,
  output logic [35:0] out_data,
  output logic        fin_sent
);

  localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic SRC_RESP = 1'b0;
  localparam logic SRC_ACT  = 1'b1;

  typedef struct packed {
    logic [7:0]  dst;
    logic [5:0]  addr;
    logic [15:0] data;
  } resp_t;

  resp_t          mem [RESP_DEPTH];
  resp_t          head;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, push, pop;
  logic [CW-1:0]  credit;
  logic           can_send, send;
  logic           rr_ptr;
  logic           fin_pend;
  logic           gnt_resp, gnt_act, gnt_fin;
  logic [35:0]    flit;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_resp_rdy = !full;
  assign push  = rd_resp_valid && !full;
  assign pop   = gnt_resp;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{dst: rd_resp_dst, addr: rd_resp_addr, data: rd_resp_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign can_send = (credit != '0);

  // FIN only goes out once both data sources are idle so it trails all prior traffic.
  always_comb begin
    gnt_resp = 1'b0;
    gnt_act  = 1'b0;
    gnt_fin  = 1'b0;
    if (can_send) begin
      if (!empty && out_act_valid) begin
        if (rr_ptr == SRC_ACT) gnt_act  = 1'b1;
        else                   gnt_resp = 1'b1;
      end else if (!empty)       gnt_resp = 1'b1;
      else if (out_act_valid)    gnt_act  = 1'b1;
      else if (fin_pend)         gnt_fin  = 1'b1;
    end
  end

  assign send        = gnt_resp || gnt_act || gnt_fin;
  assign out_act_rdy = gnt_act;

  always_comb begin
    flit = '0;
    if (gnt_resp)     flit = {INFO_RD_RESP, head.dst, 1'b1, head.addr, 1'b0, head.data};
    else if (gnt_act) flit = {INFO_ACT_OUT, out_act_addr, out_act_data};
    else if (gnt_fin) flit = {INFO_FIN_COMP, 10'b0, PE_IDX, 16'h0000};
  end

  // A credit return that would overflow the counter is a router fault and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= CRED_MAX;
    end else begin
      case ({downstream_credit, send})
        2'b10:   if (credit != CRED_MAX) credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= SRC_RESP;
    end else if (gnt_resp) begin
      rr_ptr <= SRC_ACT;
    end else if (gnt_act) begin
      rr_ptr <= SRC_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fin_pend <= 1'b0;
      fin_sent <= 1'b0;
    end else if (gnt_fin) begin
      fin_pend <= 1'b0;
      fin_sent <= 1'b1;
    end else if (comp_fin && !fin_pend && !fin_sent) begin
      fin_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_valid <= 1'b0;
      out_data       <= '0;
    end else begin
      out_data_valid <= send;
      out_data       <= flit;
    end
  end

endmodule

// File: tb/tb_ni_output_unit.sv
// Bench for ni_output_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed flit values and counts.
module tb_ni_output_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  PE_IDX = '0;
  logic        rd_resp_valid = 1'b0;
  logic [7:0]  rd_resp_dst = '0;
  logic [5:0]  rd_resp_addr = '0;
  logic [15:0] rd_resp_data = '0;
  logic        rd_resp_rdy;
  logic        out_act_valid = 1'b0;
  logic [15:0] out_act_addr = '0;
  logic [15:0] out_act_data = '0;
  logic        out_act_rdy;
  logic        comp_fin = 1'b0;
  logic        downstream_credit = 1'b0;
  logic        out_data_valid;
  logic [35:0] out_data;
  logic        fin_sent;

  ni_output_unit dut (
    .clk(clk), .rst(rst), .PE_IDX(PE_IDX),
    .rd_resp_valid(rd_resp_valid), .rd_resp_dst(rd_resp_dst),
    .rd_resp_addr(rd_resp_addr), .rd_resp_data(rd_resp_data), .rd_resp_rdy(rd_resp_rdy),
    .out_act_valid(out_act_valid), .out_act_addr(out_act_addr),
    .out_act_data(out_act_data), .out_act_rdy(out_act_rdy),
    .comp_fin(comp_fin), .downstream_credit(downstream_credit),
    .out_data_valid(out_data_valid), .out_data(out_data), .fin_sent(fin_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [35:0] flits[$];

  // Reference model state
  logic [29:0] m_q[$];
  int          m_credit   = 4;
  bit          m_ptr_act  = 1'b0;
  bit          m_fin_pend = 1'b0;
  bit          m_fin_sent = 1'b0;
  logic        m_vld      = 1'b0;
  logic [35:0] m_data     = '0;

  task automatic check(input string nm, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // 0 none, 1 response, 2 activation, 3 finish
  function automatic int m_grant();
    if (m_credit == 0) return 0;
    if (m_q.size() > 0 && out_act_valid) return m_ptr_act ? 2 : 1;
    if (m_q.size() > 0) return 1;
    if (out_act_valid) return 2;
    if (m_fin_pend) return 3;
    return 0;
  endfunction

  task automatic model_step();
    int g;
    bit was_full;
    logic [29:0] h;
    if (rst) begin
      m_q.delete();
      m_credit = 4; m_ptr_act = 1'b0; m_fin_pend = 1'b0; m_fin_sent = 1'b0;
      m_vld = 1'b0; m_data = '0;
    end else begin
      g = m_grant();
      was_full = (m_q.size() >= 4);
      m_vld = (g != 0);
      m_data = '0;
      case (g)
        1: begin
          h = m_q.pop_front();
          m_data = {4'd6, h[29:22], 1'b1, h[21:16], 1'b0, h[15:0]};
          m_ptr_act = 1'b1;
        end
        2: begin
          m_data = {4'd7, out_act_addr, out_act_data};
          m_ptr_act = 1'b0;
        end
        3: begin
          m_data = {4'd5, 10'b0, PE_IDX, 16'h0000};
          m_fin_pend = 1'b0;
          m_fin_sent = 1'b1;
        end
        default: ;
      endcase
      if (rd_resp_valid && !was_full) m_q.push_back({rd_resp_dst, rd_resp_addr, rd_resp_data});
      if (downstream_credit && g == 0) begin
        if (m_credit < 4) m_credit++;
      end else if (!downstream_credit && g != 0) begin
        m_credit--;
      end
      if (g != 3 && comp_fin && !m_fin_pend && !m_fin_sent) m_fin_pend = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("valid", {35'b0, out_data_valid}, {35'b0, m_vld});
      check("data", out_data, m_data);
      check("rd_resp_rdy", {35'b0, rd_resp_rdy}, {35'b0, (m_q.size() < 4)});
      check("out_act_rdy", {35'b0, out_act_rdy}, {35'b0, (m_grant() == 2)});
      check("fin_sent", {35'b0, fin_sent}, {35'b0, m_fin_sent});
      if (out_data_valid) flits.push_back(out_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    rd_resp_valid = 1'b0; out_act_valid = 1'b0; comp_fin = 1'b0; downstream_credit = 1'b0;
  endtask

  task automatic idle(input int n);
    idle_in();
    repeat (n) tick();
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_resp(input logic [7:0] d, input logic [5:0] a, input logic [15:0] v);
    rd_resp_valid = 1'b1; rd_resp_dst = d; rd_resp_addr = a; rd_resp_data = v;
  endtask

  task automatic wait_flits(input int n, input int budget);
    int c = 0;
    while (flits.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("wait_flits", {4'b0, 32'(flits.size())}, {4'b0, 32'(n)});
  endtask

  initial begin
    int act_cnt;
    int viol;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset then idle
    idle(3);
    check("idle_valid", {35'b0, out_data_valid}, 36'd0);
    check("idle_rdy", {35'b0, rd_resp_rdy}, 36'd1);
    check("idle_fin", {35'b0, fin_sent}, 36'd0);
    check("idle_data", out_data, 36'd0);

    // Single response and its flit encoding
    flits.delete();
    push_resp(8'h03, 6'd5, 16'h00AB);
    tick();
    idle_in();
    wait_flits(1, 10);
    if (flits.size() >= 1) check("single_flit", flits[0], {4'h6, 8'h03, 8'h8A, 16'h00AB});
    // Credit now 3: four more responses without returns yield only three flits
    flits.delete();
    for (int i = 0; i < 4; i++) begin
      push_resp(8'h20, 6'(i), 16'hA000 + 16'(i));
      tick();
    end
    idle(8);
    check("credit_3_left", {4'b0, 32'(flits.size())}, 36'd3);

    // Round-robin with continuous requests and credit returns
    do_reset();
    flits.delete();
    act_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      push_resp(8'h40 + 8'(i), 6'(i), 16'h2000 + 16'(i));
      out_act_valid = 1'b1; out_act_addr = 16'h0100 + 16'(i); out_act_data = 16'h1000 + 16'(i);
      downstream_credit = 1'b1;
      #1;
      if (out_act_rdy) act_cnt++;
      tick();
    end
    idle_in();
    tick();
    check("rr_act_rdy_count", {4'b0, 32'(act_cnt)}, 36'd6);
    viol = 0;
    if (flits.size() < 12) viol = 99;
    else for (int i = 0; i < 12; i++)
      if (flits[i][35:32] != ((i % 2 == 0) ? 4'd7 : 4'd6)) viol++;
    check("rr_alternate", {4'b0, 32'(viol)}, 36'd0);
    if (flits.size() >= 2) check("rr_first_resp", flits[1], {4'h6, 8'h40, 1'b1, 6'd0, 1'b0, 16'h2000});
    idle(12);

    // Credit exhaustion, FIFO full, dropped push, single credit returns
    do_reset();
    flits.delete();
    for (int i = 0; i < 9; i++) begin
      push_resp(8'h11, 6'(i), 16'hC000 + 16'(i));
      tick();
    end
    idle(6);
    check("exhaust_4_flits", {4'b0, 32'(flits.size())}, 36'd4);
    check("exhaust_rdy_low", {35'b0, rd_resp_rdy}, 36'd0);
    flits.delete();
    downstream_credit = 1'b1; tick(); idle(6);
    check("one_credit_one_flit", {4'b0, 32'(flits.size())}, 36'd1);
    if (flits.size() >= 1) check("one_credit_order", {20'b0, flits[0][15:0]}, 36'hC004);
    flits.delete();
    downstream_credit = 1'b1; tick(); tick(); idle(6);
    check("two_credit_flits", {4'b0, 32'(flits.size())}, 36'd2);
    if (flits.size() >= 2) check("two_credit_last", {20'b0, flits[1][15:0]}, 36'hC006);
    flits.delete();
    for (int i = 0; i < 3; i++) begin
      downstream_credit = 1'b1; tick(); idle(3);
    end
    check("drop_on_full", {4'b0, 32'(flits.size())}, 36'd1);
    if (flits.size() >= 1) check("drop_last_data", {20'b0, flits[0][15:0]}, 36'hC007);

    // Finish notification trails queued responses
    do_reset();
    flits.delete();
    PE_IDX = 6'd9;
    push_resp(8'h05, 6'd1, 16'h5001); tick();
    push_resp(8'h05, 6'd2, 16'h5002); comp_fin = 1'b1; tick();
    idle(8);
    check("fin_flit_count", {4'b0, 32'(flits.size())}, 36'd3);
    if (flits.size() >= 3) begin
      check("fin_r0", {20'b0, flits[0][15:0]}, 36'h5001);
      check("fin_r1", {20'b0, flits[1][15:0]}, 36'h5002);
      check("fin_flit", flits[2], 36'h5_0009_0000);
    end
    check("fin_sent_set", {35'b0, fin_sent}, 36'd1);
    flits.delete();
    comp_fin = 1'b1; tick(); idle(6);
    check("fin_second_ignored", {4'b0, 32'(flits.size())}, 36'd0);

    // Reset with full FIFO and pending finish
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_resp(8'h22, 6'(i), 16'hD000 + 16'(i));
      tick();
    end
    idle_in();
    comp_fin = 1'b1; tick(); idle(2);
    check("pre_reset_full", {35'b0, rd_resp_rdy}, 36'd0);
    do_reset();
    flits.delete();
    idle(8);
    check("post_reset_no_flits", {4'b0, 32'(flits.size())}, 36'd0);
    check("post_reset_rdy", {35'b0, rd_resp_rdy}, 36'd1);
    check("post_reset_fin", {35'b0, fin_sent}, 36'd0);
    for (int i = 0; i < 5; i++) begin
      push_resp(8'h33, 6'(i), 16'hE000 + 16'(i));
      tick();
    end
    idle(8);
    check("post_reset_credit4", {4'b0, 32'(flits.size())}, 36'd4);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
